// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 move sequencer: FSM states,
// direction one-hot codes, game_state encodings and a one-hot test helper.
package game2048_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CLEAR   = 4'd1,
    ST_SPAWN0  = 4'd2,
    ST_SPAWN1  = 4'd3,
    ST_WAIT_IN = 4'd4,
    ST_MOVE    = 4'd5,
    ST_WAIT_DP = 4'd6,
    ST_SPAWN   = 4'd7,
    ST_CHECK   = 4'd8,
    ST_WON     = 4'd9,
    ST_LOST    = 4'd10
  } state_t;

  localparam logic [3:0] DIR_RIGHT  = 4'b1000;
  localparam logic [3:0] DIR_LEFT   = 4'b0100;
  localparam logic [3:0] DIR_BOTTOM = 4'b0010;
  localparam logic [3:0] DIR_TOP    = 4'b0001;

  localparam logic [1:0] GS_PLAY = 2'b00;
  localparam logic [1:0] GS_WON  = 2'b01;
  localparam logic [1:0] GS_LOST = 2'b10;
  localparam logic [1:0] GS_IDLE = 2'b11;

  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/game2048_ctrl_if.sv
// Controller <-> board datapath link: move handshake, clear, tile spawn
// and the board status flags the controller evaluates.
interface game2048_ctrl_if;
  logic        dp_clear;
  logic        dp_move_valid;
  logic [3:0]  dp_dir;
  logic        dp_done;
  logic        dp_changed;
  logic        dp_has_2048;
  logic        dp_can_merge;
  logic [15:0] empty_mask;
  logic        spawn_valid;
  logic [3:0]  spawn_idx;
  logic        spawn_val;

  modport master (
    output dp_clear, dp_move_valid, dp_dir, spawn_valid, spawn_idx, spawn_val,
    input  dp_done, dp_changed, dp_has_2048, dp_can_merge, empty_mask
  );

  modport slave (
    input  dp_clear, dp_move_valid, dp_dir, spawn_valid, spawn_idx, spawn_val,
    output dp_done, dp_changed, dp_has_2048, dp_can_merge, empty_mask
  );
endinterface

// File: rtl/game2048_spawn_sel.sv
// Combinational spawn-cell picker: first empty cell at or after the random
// offset, wrapping around the 16-cell board.
module game2048_spawn_sel (
  input  logic [15:0] empty_mask,
  input  logic [3:0]  offset,
  output logic [3:0]  idx,
  output logic        found
);
  logic [15:0] rot_s;
  logic [3:0]  low_s;

  // Rotate right by the offset, pick the lowest set bit, map back to a cell.
  always_comb begin
    rot_s = (empty_mask >> offset) | (empty_mask << (5'd16 - {1'b0, offset}));
    low_s = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      low_s = rot_s[i] ? 4'(i) : low_s;
    end
    idx   = low_s + offset;
    found = |empty_mask;
  end
endmodule

// File: rtl/game2048_ctrl.sv
// 2048 move sequencer: buffers one direction press, issues moves, spawns tiles
// and judges win/lose. Optional WAIT_DP watchdog: GAME2048_CTRL_TIMEOUT_EN.
module game2048_ctrl
  import game2048_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned DONE_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             btn_dir,
  game2048_ctrl_if.master        dp,
  output logic [1:0]             game_state,
  output logic                   busy,
  output logic [15:0]            move_count
);
  state_t      state_r, state_nx_s;
  logic [15:0] lfsr_r;
  logic        lfsr_fb_s;
  logic [3:0]  btn_q_r;
  logic [3:0]  pend_r;
  logic [3:0]  dp_dir_r;
  logic [15:0] move_count_r;
  logic        playing_s;
  logic        spawning_s;
  logic        to_hit_s;
  logic [3:0]  sel_idx_s;
  logic        sel_found_s;

  game2048_spawn_sel u_spawn_sel (
    .empty_mask (dp.empty_mask),
    .offset     (lfsr_r[3:0]),
    .idx        (sel_idx_s),
    .found      (sel_found_s)
  );

  assign lfsr_fb_s  = lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5];
  assign playing_s  = state_r inside {ST_WAIT_IN, ST_MOVE, ST_WAIT_DP, ST_SPAWN, ST_CHECK};
  assign spawning_s = state_r inside {ST_SPAWN0, ST_SPAWN1, ST_SPAWN};

`ifdef GAME2048_CTRL_TIMEOUT_EN
  logic [15:0] to_cnt_r;

  // Watchdog counting cycles spent in WAIT_DP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_r <= 16'd0;
    end else if (state_r != ST_WAIT_DP) begin
      to_cnt_r <= 16'd0;
    end else begin
      to_cnt_r <= to_cnt_r + 16'd1;
    end
  end
  assign to_hit_s = (to_cnt_r == 16'(DONE_TIMEOUT - 1));
`else
  assign to_hit_s = 1'b0;
`endif

  // Next-state logic; start overrides everything.
  always_comb begin
    state_nx_s = state_r;
    if (start) begin
      state_nx_s = ST_CLEAR;
    end else begin
      case (state_r)
        ST_IDLE:    state_nx_s = ST_IDLE;
        ST_CLEAR:   state_nx_s = ST_SPAWN0;
        ST_SPAWN0:  state_nx_s = ST_SPAWN1;
        ST_SPAWN1:  state_nx_s = ST_WAIT_IN;
        ST_WAIT_IN: state_nx_s = (pend_r != 4'd0) ? ST_MOVE : ST_WAIT_IN;
        ST_MOVE:    state_nx_s = ST_WAIT_DP;
        ST_WAIT_DP: begin
          if (dp.dp_done) begin
            state_nx_s = dp.dp_changed ? ST_SPAWN : ST_WAIT_IN;
          end else begin
            state_nx_s = to_hit_s ? ST_IDLE : ST_WAIT_DP;
          end
        end
        ST_SPAWN:   state_nx_s = ST_CHECK;
        ST_CHECK: begin
          if (dp.dp_has_2048) begin
            state_nx_s = ST_WON;
          end else if ((dp.empty_mask == 16'd0) && !dp.dp_can_merge) begin
            state_nx_s = ST_LOST;
          end else begin
            state_nx_s = ST_WAIT_IN;
          end
        end
        ST_WON:     state_nx_s = ST_WON;
        ST_LOST:    state_nx_s = ST_LOST;
        default:    state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State, LFSR, press buffering, issued direction and move counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      lfsr_r       <= LFSR_SEED;
      btn_q_r      <= 4'd0;
      pend_r       <= 4'd0;
      dp_dir_r     <= 4'd0;
      move_count_r <= 16'd0;
    end else begin
      state_r <= state_nx_s;
      lfsr_r  <= {lfsr_fb_s, lfsr_r[15:1]};
      if (start) begin
        btn_q_r      <= 4'd0;
        pend_r       <= 4'd0;
        dp_dir_r     <= 4'd0;
        move_count_r <= 16'd0;
      end else begin
        btn_q_r <= btn_dir;
        if ((state_r == ST_WAIT_IN) && (pend_r != 4'd0)) begin
          dp_dir_r <= pend_r;
          pend_r   <= 4'd0;
        end else if (playing_s && (pend_r == 4'd0) && is_one_hot4(btn_q_r)) begin
          pend_r <= btn_q_r;
        end else begin
          pend_r <= pend_r;
        end
        if (state_r == ST_CLEAR) begin
          move_count_r <= 16'd0;
        end else if ((state_r == ST_WAIT_DP) && dp.dp_done && dp.dp_changed &&
                     (move_count_r != 16'hFFFF)) begin
          move_count_r <= move_count_r + 16'd1;
        end else begin
          move_count_r <= move_count_r;
        end
      end
    end
  end

  // Moore output decode from the state register.
  always_comb begin
    dp.dp_clear      = (state_r == ST_CLEAR);
    dp.dp_move_valid = (state_r == ST_MOVE);
    dp.dp_dir        = dp_dir_r;
    dp.spawn_valid   = spawning_s && sel_found_s;
    dp.spawn_idx     = spawning_s ? sel_idx_s : 4'd0;
    dp.spawn_val     = spawning_s && (lfsr_r[7:4] == 4'd0);
    busy             = !(state_r inside {ST_WAIT_IN, ST_WON, ST_LOST, ST_IDLE});
    move_count       = move_count_r;
    case (state_r)
      ST_IDLE: game_state = GS_IDLE;
      ST_WON:  game_state = GS_WON;
      ST_LOST: game_state = GS_LOST;
      default: game_state = GS_PLAY;
    endcase
  end
endmodule

// File: tb/tb_game2048_ctrl.sv
// Directed self-checking bench for game2048_ctrl with a direction scoreboard
// and a reference LFSR / spawn-cell model.
module tb_game2048_ctrl;
  import game2048_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  btn_dir;
  logic [1:0]  game_state;
  logic        busy;
  logic [15:0] move_count;

  int checks = 0;
  int errors = 0;
  int mv_seen = 0;
  logic [15:0] m_lfsr;
  logic [3:0]  exp_dir_q[$];

  game2048_ctrl_if dp_if ();

  game2048_ctrl #(.LFSR_SEED(SEED), .DONE_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .btn_dir    (btn_dir),
    .dp         (dp_if),
    .game_state (game_state),
    .busy       (busy),
    .move_count (move_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  always @(posedge clk) m_lfsr <= !rst ? SEED : lfsr_next(m_lfsr);
  always @(posedge clk) if (dp_if.dp_move_valid === 1'b1) mv_seen <= mv_seen + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    btn_dir = d;
    @(negedge clk);
    btn_dir = 4'd0;
  endtask

  // Wait for the move request, compare against the scoreboard, check one-cycle strobe.
  task automatic expect_move(input string tag, input bit chk_lat);
    int n;
    logic [3:0] e;
    n = 1;
    while (dp_if.dp_move_valid !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, dp_if.dp_move_valid, 1'b1);
    if (chk_lat) check({tag, "_lat"}, n - 1, 2);
    check({tag, "_q"}, exp_dir_q.size() > 0, 1'b1);
    e = (exp_dir_q.size() > 0) ? exp_dir_q.pop_front() : 4'd0;
    check({tag, "_dir"}, dp_if.dp_dir, e);
    @(negedge clk);
    check({tag, "_pulse"}, dp_if.dp_move_valid, 1'b0);
    check({tag, "_hold"}, dp_if.dp_dir, e);
  endtask

  task automatic reply(input logic chg);
    dp_if.dp_changed = chg;
    dp_if.dp_done    = 1'b1;
    @(negedge clk);
    dp_if.dp_done    = 1'b0;
    dp_if.dp_changed = 1'b0;
  endtask

  // Expected spawn from the model LFSR; the bench datapath then fills the cell.
  task automatic check_spawn(input string tag, output logic [3:0] got);
    logic [3:0] off, c, ei;
    logic ef, ev;
    off = m_lfsr[3:0];
    ef  = 1'b0;
    ei  = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      c = off + 4'(k);
      if (dp_if.empty_mask[c]) begin
        ei = c;
        ef = 1'b1;
      end
    end
    ev  = (m_lfsr[7:4] == 4'd0);
    got = dp_if.spawn_idx;
    check({tag, "_valid"}, dp_if.spawn_valid, ef);
    if (ef) begin
      check({tag, "_idx"}, dp_if.spawn_idx, ei);
      check({tag, "_val"}, dp_if.spawn_val, ev);
      dp_if.empty_mask[ei] = 1'b0;
    end
  endtask

  task automatic new_game(input string tag);
    logic [3:0] i0, i1;
    dp_if.empty_mask  = 16'hFFFF;
    dp_if.dp_has_2048 = 1'b0;
    dp_if.dp_can_merge = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clr"}, dp_if.dp_clear, 1'b1);
    @(negedge clk);
    check({tag, "_clr_pulse"}, dp_if.dp_clear, 1'b0);
    check({tag, "_mc0"}, move_count, 16'd0);
    check_spawn({tag, "_s0"}, i0);
    @(negedge clk);
    check_spawn({tag, "_s1"}, i1);
    check({tag, "_distinct"}, i0 != i1, 1'b1);
    @(negedge clk);
    check({tag, "_gs"}, game_state, GS_PLAY);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [3:0] tmp;
    int n0;
    rst = 1'b0; start = 1'b0; btn_dir = 4'd0;
    dp_if.dp_done = 1'b0; dp_if.dp_changed = 1'b0;
    dp_if.dp_has_2048 = 1'b0; dp_if.dp_can_merge = 1'b0;
    dp_if.empty_mask = 16'hFFFF;
    repeat (2) @(negedge clk);
    check("rst_gs", game_state, 2'b11);
    check("rst_busy", busy, 1'b0);
    check("rst_clr", dp_if.dp_clear, 1'b0);
    check("rst_mv", dp_if.dp_move_valid, 1'b0);
    check("rst_sp", dp_if.spawn_valid, 1'b0);
    check("rst_mc", move_count, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_gs", game_state, 2'b11);
    new_game("ng1");

    // effective move
    exp_dir_q.push_back(DIR_RIGHT);
    press(DIR_RIGHT);
    expect_move("mv1", 1'b1);
    @(negedge clk);
    check("mv1_wait_busy", busy, 1'b1);
    reply(1'b1);
    check_spawn("sp1", tmp);
    check("sp1_mc", move_count, 16'd1);
    @(negedge clk);
    check("chk1_sp_pulse", dp_if.spawn_valid, 1'b0);
    check("chk1_busy", busy, 1'b1);
    @(negedge clk);
    check("wi1_busy", busy, 1'b0);
    check("wi1_gs", game_state, GS_PLAY);

    // no-op move
    exp_dir_q.push_back(DIR_TOP);
    press(DIR_TOP);
    expect_move("mv2", 1'b1);
    reply(1'b0);
    check("noop_sp", dp_if.spawn_valid, 1'b0);
    check("noop_busy", busy, 1'b0);
    check("noop_mc", move_count, 16'd1);

    // non-one-hot press ignored
    n0 = mv_seen;
    press(4'b1100);
    repeat (5) @(negedge clk);
    check("bad_press", mv_seen - n0, 0);

    // two presses while busy: only the first survives
    exp_dir_q.push_back(DIR_RIGHT);
    press(DIR_RIGHT);
    expect_move("mv3", 1'b1);
    exp_dir_q.push_back(DIR_LEFT);
    press(DIR_LEFT);
    press(DIR_BOTTOM);
    reply(1'b1);
    check_spawn("sp3", tmp);
    @(negedge clk);
    @(negedge clk);
    expect_move("mv4", 1'b0);
    reply(1'b0);
    n0 = mv_seen;
    repeat (5) @(negedge clk);
    check("drop_2nd", mv_seen - n0, 0);
    check("mc2", move_count, 16'd2);

    // win
    exp_dir_q.push_back(DIR_BOTTOM);
    press(DIR_BOTTOM);
    expect_move("mv5", 1'b1);
    reply(1'b1);
    dp_if.dp_has_2048 = 1'b1;
    check_spawn("sp5", tmp);
    check("mc3", move_count, 16'd3);
    @(negedge clk);
    @(negedge clk);
    check("won_gs", game_state, GS_WON);
    check("won_busy", busy, 1'b0);
    n0 = mv_seen;
    press(DIR_RIGHT);
    repeat (5) @(negedge clk);
    check("won_press", mv_seen - n0, 0);
    check("won_stay", game_state, GS_WON);
    new_game("ng2");

    // lose: full board, nothing mergeable, spawn skipped
    exp_dir_q.push_back(DIR_TOP);
    press(DIR_TOP);
    expect_move("mv6", 1'b1);
    dp_if.empty_mask = 16'd0;
    reply(1'b1);
    check_spawn("sp6", tmp);
    check("mc_lose", move_count, 16'd1);
    @(negedge clk);
    @(negedge clk);
    check("lost_gs", game_state, GS_LOST);
    check("lost_busy", busy, 1'b0);
    new_game("ng3");

`ifdef GAME2048_CTRL_TIMEOUT_EN
    exp_dir_q.push_back(DIR_LEFT);
    press(DIR_LEFT);
    expect_move("mv7", 1'b1);
    repeat (7) @(negedge clk);
    check("to_before", game_state, GS_PLAY);
    @(negedge clk);
    check("to_gs", game_state, GS_IDLE);
    check("to_busy", busy, 1'b0);
    new_game("ng4");
`endif

    check("sb_empty", exp_dir_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game2048_ctrl.md
# game2048_ctrl

Move sequencer for the 2048 board datapath. Accepts one-hot direction presses and a start strobe, issues one move at a time to the board datapath, and waits for completion. After every move that changed the board it spawns a new tile into an LFSR-chosen empty cell, then evaluates win/lose and drives `game_state`. It sits between the input front end (debounced buttons) and the `game2048` board/score datapath.

## Interface
- `LFSR_SEED`, 16'hACE1: nonzero LFSR reset value.
- `DONE_TIMEOUT`, 64: maximum cycles to wait for `dp_done` (only used with the timeout macro).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse that begins a new game from any state.
- `btn_dir` in 4: direction press, one-hot: 1000 right, 0100 left, 0010 bottom, 0001 top.
- `dp_done` in 1: one-cycle pulse, datapath finished the move.
- `dp_changed` in 1: qualifies `dp_done`; the board changed.
- `dp_has_2048` in 1: some tile is ≥2048.
- `dp_can_merge` in 1: some adjacent equal pair exists.
- `empty_mask` in 16: bit `4*row+col` is set when that cell is empty.
- `dp_clear` out 1: one-cycle pulse that zeroes the board and score.
- `dp_move_valid` out 1: one-cycle move request.
- `dp_dir` out 4: direction, held from `dp_move_valid` through `dp_done`.
- `spawn_valid` out 1: one-cycle tile write.
- `spawn_idx` out 4: target cell.
- `spawn_val` out 1: 0 writes tile 2, 1 writes tile 4.
- `game_state` out 2: 00 playing, 01 won, 10 lost, 11 idle/error.
- `busy` out 1: high in every state except WAIT_IN, WON, LOST and IDLE.
- `move_count` out 16: number of effective (board-changing) moves.

## Operation
- **States:** IDLE, CLEAR, SPAWN0, SPAWN1, WAIT_IN, MOVE, WAIT_DP, SPAWN, CHECK, WON, LOST.
- **Reset values:**
  - FSM is in IDLE.
  - All outputs are 0, except `game_state`=11.
  - LFSR holds `LFSR_SEED`.
  - Pending register is empty.
- **New game:** `start` (in any state) → CLEAR, which pulses `dp_clear` and zeroes `move_count`. Then SPAWN0 and SPAWN1 each issue one spawn. Then WAIT_IN with `game_state`=00. `start` has priority over every other input.
- **Pending register:**
  - Captures `btn_dir` when it is exactly one-hot and the register is empty, in any playing state.
  - Non-one-hot values, including 0000, are ignored.
  - While the register is full, further presses are dropped.
  - It is cleared on consumption, on `start`, and on reset.
- **WAIT_IN:** if the pending register is full, go to MOVE. In MOVE, `dp_move_valid`=1 for one cycle with `dp_dir` set to the pending value, and the pending register is consumed. Then go to WAIT_DP.
- **WAIT_DP:** on `dp_done`:
  - If `dp_changed`=1: increment `move_count` (saturates at FFFF), go to SPAWN.
  - If `dp_changed`=0: go to WAIT_IN. No spawn, no count.
- **Spawn selection:**
  - Rotate `empty_mask` right by `lfsr[3:0]`.
  - Take the lowest set bit and add back the offset, mod 16. That is `spawn_idx`.
  - `spawn_val`=1 when `lfsr[7:4]`==0, otherwise 0.
  - If `empty_mask`==0, skip the spawn: `spawn_valid` stays 0.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle.
- **CHECK** (one cycle after SPAWN, datapath flags already updated):
  - If `dp_has_2048`: go to WON, `game_state`=01.
  - Else if `empty_mask`==0 and !`dp_can_merge`: go to LOST, `game_state`=10.
  - Else go to WAIT_IN.
- **WON/LOST:** terminal. The FSM leaves only on `start` or reset; presses are ignored.
- **Initial spawns:** SPAWN0 and SPAWN1 use successive LFSR values. SPAWN1 sees the updated `empty_mask`, so it never targets the same cell as SPAWN0.

## Timing
- **Press to move:** `btn_dir` sampled at edge N, pending full at N+1, FSM enters MOVE at N+2. `dp_move_valid` is high during cycle N+2 (min 2-cycle latency from an idle WAIT_IN).
- **Spawn timing:** `dp_done` at edge M → SPAWN entered at M+1, `spawn_valid` high during that cycle → CHECK at M+2 → next state at M+3.
- **Output widths:** all strobes are exactly one cycle. `dp_dir` is stable from MOVE until WAIT_DP exits.
- **`dp_done` timing:** `dp_done` outside WAIT_DP is ignored.
- **Reset mid-move:** any in-flight move is abandoned; the datapath owner handles its own reset.

## Configuration
- `GAME2048_CTRL_TIMEOUT_EN`
  - **Defined:** a counter runs in WAIT_DP. If `DONE_TIMEOUT` cycles pass without `dp_done`, the FSM goes to IDLE with `game_state`=11 (error); only `start` recovers.
  - **Undefined:** the FSM waits in WAIT_DP indefinitely. No counter logic is generated.

## Structure
- Package `game2048_pkg` holds:
  - the state enum,
  - the direction constants `DIR_RIGHT`/`DIR_LEFT`/`DIR_BOTTOM`/`DIR_TOP`,
  - the `game_state` encodings `GS_PLAY`/`GS_WON`/`GS_LOST`/`GS_IDLE`.
- Sub-module `game2048_spawn_sel`: a combinational rotate/priority picker (`empty_mask`, offset → `idx`, `found`).
- The LFSR stays inline in the controller.

## Test plan
- **Reset and start:** reset low 2 cycles, then `start` pulse with `empty_mask`=FFFF → `game_state`=11 until start. `dp_clear` pulses once. Two `spawn_valid` pulses with distinct `spawn_idx`, then `game_state`=00.
- **Effective move:** `btn_dir`=1000 → `dp_move_valid` 2 cycles later with `dp_dir`=1000. Reply `dp_done`+`dp_changed` → one spawn into an empty cell, `move_count`=1.
- **No-op move:** `btn_dir`=0001, reply `dp_done` with `dp_changed`=0 → no `spawn_valid`, `move_count` unchanged, FSM back in WAIT_IN.
- **Press handling:**
  - `btn_dir`=1100 → ignored.
  - Two presses during WAIT_DP (0100 then 0010) → only 0100 is issued next.
- **Win and lose:**
  - `dp_has_2048`=1 at CHECK → `game_state`=01, later presses ignored.
  - `empty_mask`=0 with `dp_can_merge`=0 → `game_state`=10.
  - `start` from either → new game.
- **Timeout (macro defined, `DONE_TIMEOUT`=8):** withhold `dp_done` → `game_state`=11 after 8 cycles in WAIT_DP.
